mem_arbiter: RTL and testbench

Shares the single memory port of the surov memory interface between `N_REQ` requesters, e.g. a core and a DMA/debug master. Each cycle it grants at most one read or write in round-robin order, forwards that transfer to memory, and routes the one-cycle-latency read data back to the issuing requester. A lock input keeps ownership across several transfers so a requester can do an atomic read-modify-write.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between N_REQ requesters with
// round-robin (or fixed-priority) arbitration, bus lock and read return.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   req_rden/wren/lock [N]   per-requester read/write strobes and lock
//   req_addr/wdata [N][XLEN] per-requester address and write data
//   req_size [N][2]          per-requester access size (0 B, 1 H, 2 W)
//   req_gnt [N]              one-hot grant, transfer happens this cycle
//   req_rvalid [N]           read data valid, one cycle after read grant
//   req_rdata [XLEN]         shared read data (mirrors mem_rdata)
//   mem_*                    single memory port
//
// Build option: define MEMARB_RR_EN for round-robin arbitration;
// without it the lowest active index wins and no `last` state exists.
module mem_arbiter #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_rden,
    input  logic [N_REQ-1:0]           req_wren,
    input  logic [N_REQ-1:0]           req_lock,
    input  logic [N_REQ-1:0][XLEN-1:0] req_addr,
    input  logic [N_REQ-1:0][1:0]      req_size,
    input  logic [N_REQ-1:0][XLEN-1:0] req_wdata,
    output logic [N_REQ-1:0]           req_gnt,
    output logic [N_REQ-1:0]           req_rvalid,
    output logic [XLEN-1:0]            req_rdata,
    output logic [XLEN-1:0]            mem_addr,
    output logic                       mem_rden,
    output logic                       mem_wren,
    output logic [1:0]                 mem_size,
    output logic [XLEN-1:0]            mem_wdata,
    input  logic [XLEN-1:0]            mem_rdata
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   owner_d;
    logic            rd_pend_q;
    logic            rd_pend_d;
    logic [IW-1:0]   rd_id_q;
    logic [IW-1:0]   rd_id_d;
`ifdef MEMARB_RR_EN
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   last_d;
`endif

    logic [N_REQ-1:0] active;
    logic             hold;
    logic             gnt_vld;
    logic [IW-1:0]    win;
    logic [IW-1:0]    cand;
    logic             rd_go;
    logic             wr_go;

    // Arbitration: a held lock pins the grant to the owner; otherwise
    // pick the first active requester in search order.
    always_comb begin
        active  = req_rden | req_wren;
        hold    = (state_q == LOCKED) && req_lock[owner_q];
        gnt_vld = 1'b0;
        win     = '0;
        cand    = '0;
        if (hold) begin
            gnt_vld = active[owner_q];
            win     = owner_q;
        end else begin
`ifdef MEMARB_RR_EN
            for (int k = 1; k <= N_REQ; k++) begin
                cand = IW'((int'(last_q) + k) % N_REQ);
                if (!gnt_vld && active[cand]) begin
                    gnt_vld = 1'b1;
                    win     = cand;
                end
            end
`else
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = IW'(k);
                if (active[cand]) begin
                    gnt_vld = 1'b1;
                    win     = cand;
                end
            end
`endif
        end
        // No grant can leak out while reset is held.
        if (!rst) begin
            gnt_vld = 1'b0;
        end
    end

    // A write wins over a simultaneous (illegal) read on one requester.
    always_comb begin
        wr_go     = gnt_vld & req_wren[win];
        rd_go     = gnt_vld & req_rden[win] & ~req_wren[win];
        req_gnt   = gnt_vld ? (N_REQ'(1) << win) : '0;
        mem_rden  = rd_go;
        mem_wren  = wr_go;
        mem_addr  = gnt_vld ? req_addr[win] : '0;
        mem_size  = gnt_vld ? req_size[win] : 2'd0;
        mem_wdata = gnt_vld ? req_wdata[win] : '0;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        if (!hold) begin
            if (gnt_vld && req_lock[win]) begin
                state_d = LOCKED;
                owner_d = win;
            end else begin
                state_d = IDLE;
            end
        end
        rd_pend_d = rd_go;
        rd_id_d   = rd_go ? win : rd_id_q;
`ifdef MEMARB_RR_EN
        last_d    = gnt_vld ? win : last_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
`ifdef MEMARB_RR_EN
            last_q    <= IW'(N_REQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
`ifdef MEMARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign req_rvalid = rd_pend_q ? (N_REQ'(1) << rd_id_q) : '0;
    assign req_rdata  = mem_rdata;

    a_no_rd_wr: assert property (
        @(posedge clk) disable iff (!rst) ((req_rden & req_wren) == '0)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        r_rden, r_wren, r_lock;
    logic [1:0][31:0]  r_addr, r_wdata;
    logic [1:0][1:0]   r_size;
    logic [31:0]       m_rdata;
    logic [1:0]        o_gnt, o_rvalid;
    logic [31:0]       o_rdata, o_maddr, o_mwdata;
    logic              o_mrden, o_mwren;
    logic [1:0]        o_msize;

    logic [2:0]        t_rden, t_wren, t_lock;
    logic [2:0][31:0]  t_addr, t_wdata;
    logic [2:0][1:0]   t_size;
    logic [2:0]        t_gnt, t_rvalid;
    logic [31:0]       t_rdata, t_maddr, t_mwdata;
    logic              t_mrden, t_mwren;
    logic [1:0]        t_msize;

    mem_arbiter #(.N_REQ(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_rden(r_rden), .req_wren(r_wren), .req_lock(r_lock),
        .req_addr(r_addr), .req_size(r_size), .req_wdata(r_wdata),
        .req_gnt(o_gnt), .req_rvalid(o_rvalid), .req_rdata(o_rdata),
        .mem_addr(o_maddr), .mem_rden(o_mrden), .mem_wren(o_mwren),
        .mem_size(o_msize), .mem_wdata(o_mwdata), .mem_rdata(m_rdata)
    );

    mem_arbiter #(.N_REQ(3), .XLEN(32)) dut3 (
        .clk(clk), .rst(rst),
        .req_rden(t_rden), .req_wren(t_wren), .req_lock(t_lock),
        .req_addr(t_addr), .req_size(t_size), .req_wdata(t_wdata),
        .req_gnt(t_gnt), .req_rvalid(t_rvalid), .req_rdata(t_rdata),
        .mem_addr(t_maddr), .mem_rden(t_mrden), .mem_wren(t_mwren),
        .mem_size(t_msize), .mem_wdata(t_mwdata), .mem_rdata(m_rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state (2-requester instance).
    int m_last;
    bit m_locked;
    int m_owner;
    int m_rv;

    function automatic int exp_win();
        logic [1:0] act;
        act = r_rden | r_wren;
        if (!rst) return -1;
        if (m_locked && r_lock[m_owner]) return act[m_owner] ? m_owner : -1;
`ifdef MEMARB_RR_EN
        for (int k = 1; k <= 2; k++)
            if (act[(m_last + k) % 2]) return (m_last + k) % 2;
`else
        for (int i = 0; i < 2; i++)
            if (act[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 1;
        m_locked = 0;
        m_owner = 0;
        m_rv = -1;
    endtask

    task automatic tick();
        int w;
        bit hold;
        w = exp_win();
        if (rst) begin
            hold = m_locked && r_lock[m_owner];
            if (!hold) begin
                if (w >= 0 && r_lock[w]) begin
                    m_locked = 1;
                    m_owner = w;
                end else begin
                    m_locked = 0;
                end
            end
            if (w >= 0) m_last = w;
            m_rv = (w >= 0 && r_rden[w] && !r_wren[w]) ? w : -1;
        end
        @(posedge clk);
        #1;
        m_rdata = $urandom;
    endtask

    task automatic clear_inputs();
        r_rden = '0; r_wren = '0; r_lock = '0;
        r_addr = '0; r_wdata = '0; r_size = '0;
        t_rden = '0; t_wren = '0; t_lock = '0;
        t_addr = '0; t_wdata = '0; t_size = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        clear_inputs();
        r_rden = 2'b11;
        t_rden = 3'b111;
        rst = 1'b0;
        #2;
        n_cmp++;
        if (o_gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b want 00", o_gnt);
        end
        n_cmp++;
        if (o_rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rvalid: got %b want 00", o_rvalid);
        end
        n_cmp++;
        if ({o_mrden, o_mwren} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00", {o_mrden, o_mwren});
        end
        n_cmp++;
        if (t_gnt !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gnt3: got %b want 000", t_gnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (o_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_prio: got %b want 01", o_gnt);
        end
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_alternate();
        logic [1:0] eg;
        logic [1:0] erv;
        do_reset();
        r_rden = 2'b11;
        r_size = {2'd2, 2'd2};
        r_addr = {32'h200, 32'h100};
        erv = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
`ifdef MEMARB_RR_EN
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            n_cmp++;
            if (o_gnt !== eg) begin
                n_fail++;
                $display("FAIL alt_gnt[%0d]: got %b want %b", c, o_gnt, eg);
            end
            n_cmp++;
            if (o_rvalid !== erv) begin
                n_fail++;
                $display("FAIL alt_rvalid[%0d]: got %b want %b", c, o_rvalid, erv);
            end
            n_cmp++;
            if (o_rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL alt_rdata[%0d]: got %h want %h", c, o_rdata, m_rdata);
            end
            erv = eg;
            tick();
        end
        clear_inputs();
        @(negedge clk);
        n_cmp++;
        if (o_rvalid !== erv) begin
            n_fail++;
            $display("FAIL alt_rvalid_last: got %b want %b", o_rvalid, erv);
        end
        tick();
    endtask

    task automatic test_write();
        do_reset();
        r_wren = 2'b10;
        r_addr[1] = 32'h100;
        r_size[1] = 2'd2;
        r_wdata[1] = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if ({o_mwren, o_mrden} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_strobe: got %b want 10", {o_mwren, o_mrden});
        end
        n_cmp++;
        if (o_maddr !== 32'h100 || o_msize !== 2'd2) begin
            n_fail++;
            $display("FAIL wr_addr: got %h/%0d want 100/2", o_maddr, o_msize);
        end
        n_cmp++;
        if (o_mwdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_wdata: got %h want deadbeef", o_mwdata);
        end
        n_cmp++;
        if (o_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_gnt: got %b want 10", o_gnt);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        n_cmp++;
        if (o_rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: got %b want 00", o_rvalid);
        end
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        r_rden = 2'b11;
        r_lock = 2'b01;
        r_addr = {32'h40, 32'h80};
        @(negedge clk);
        n_cmp++;
        if (o_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_a_gnt: got %b want 01", o_gnt);
        end
        tick();
        r_rden = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (o_gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL lock_idle_gnt: got %b want 00", o_gnt);
        end
        n_cmp++;
        if (o_rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_rvalid: got %b want 01", o_rvalid);
        end
        tick();
        r_wren = 2'b01;
        r_wdata[0] = 32'h1234_5678;
        @(negedge clk);
        n_cmp++;
        if (o_gnt !== 2'b01 || o_mwren !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_wr: got gnt %b wren %b want 01 1", o_gnt, o_mwren);
        end
        tick();
        r_wren = 2'b00;
        r_lock = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (o_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_release: got %b want 10", o_gnt);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        r_rden = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (o_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_gnt: got %b want 01", o_gnt);
        end
        tick();
        rst = 1'b0;
        r_rden = 2'b11;
        #1;
        n_cmp++;
        if (o_rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_rvalid: got %b want 00", o_rvalid);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (o_gnt !== 2'b01 || o_rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_after: got gnt %b rv %b want 01 00", o_gnt, o_rvalid);
        end
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap3();
        logic [2:0] eg;
        do_reset();
        t_rden = 3'b111;
        t_size = {2'd2, 2'd2, 2'd2};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
`ifdef MEMARB_RR_EN
            eg = 3'(1 << (c % 3));
`else
            eg = 3'b001;
`endif
            n_cmp++;
            if (t_gnt !== eg) begin
                n_fail++;
                $display("FAIL wrap3[%0d]: got %b want %b", c, t_gnt, eg);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        r_rden = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (o_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_g0: got %b want 01", o_gnt);
        end
        tick();
        r_rden = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (o_gnt !== 2'b10 || o_rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_c1: got gnt %b rv %b want 10 01", o_gnt, o_rvalid);
        end
        tick();
        r_rden = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (o_rvalid !== 2'b10 || o_rdata !== m_rdata) begin
            n_fail++;
            $display("FAIL b2b_c2: got rv %b rd %h want 10 %h", o_rvalid, o_rdata, m_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        bit pend[2];
        int w;
        bit rw;
        logic [1:0] eg, erv;
        logic [31:0] ea, ewd;
        logic [1:0] es;
        logic erd, ewr;
        do_reset();
        pend[0] = 0;
        pend[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        pend[i] = 1;
                        rw = 1'($urandom_range(0, 1));
                        r_rden[i] = rw;
                        r_wren[i] = !rw;
                        r_addr[i] = $urandom;
                        r_size[i] = 2'($urandom_range(0, 2));
                        r_wdata[i] = $urandom;
                        r_lock[i] = ($urandom_range(0, 3) == 0);
                    end else begin
                        r_rden[i] = 0;
                        r_wren[i] = 0;
                        r_lock[i] = 1'($urandom_range(0, 1));
                    end
                end
            end
            @(negedge clk);
            w = exp_win();
            eg = (w >= 0) ? 2'(1 << w) : 2'b00;
            erv = (m_rv >= 0) ? 2'(1 << m_rv) : 2'b00;
            erd = (w >= 0) ? (r_rden[w] & ~r_wren[w]) : 1'b0;
            ewr = (w >= 0) ? r_wren[w] : 1'b0;
            ea = (w >= 0) ? r_addr[w] : 32'h0;
            ewd = (w >= 0) ? r_wdata[w] : 32'h0;
            es = (w >= 0) ? r_size[w] : 2'd0;
            n_cmp++;
            if (o_gnt !== eg) begin
                n_fail++;
                $display("FAIL rnd_gnt[%0d]: got %b want %b", c, o_gnt, eg);
            end
            n_cmp++;
            if (o_rvalid !== erv || o_rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL rnd_rvalid[%0d]: got %b/%h want %b/%h", c, o_rvalid, o_rdata, erv, m_rdata);
            end
            n_cmp++;
            if ({o_mrden, o_mwren} !== {erd, ewr}) begin
                n_fail++;
                $display("FAIL rnd_strobe[%0d]: got %b want %b", c, {o_mrden, o_mwren}, {erd, ewr});
            end
            n_cmp++;
            if (o_maddr !== ea || o_mwdata !== ewd || o_msize !== es) begin
                n_fail++;
                $display("FAIL rnd_bus[%0d]: got %h/%h/%0d want %h/%h/%0d", c, o_maddr, o_mwdata, o_msize, ea, ewd, es);
            end
            tick();
            if (w >= 0) pend[w] = 0;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        m_rdata = 32'hA5A5_0001;
        clear_inputs();
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_alternate();
        test_write();
        test_lock();
        test_reset_mid();
        test_wrap3();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
